// File: rtl/prog_counter_pkg.sv
// Shared types and constants for the programmable counter/timer.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_PING    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  // CTRL register bit positions
  localparam int unsigned CTRL_RUN     = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_LOAD    = 3;
  localparam int unsigned CTRL_CLR     = 4;

  // Config register addresses
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_LIMIT    = 2'd2;
  localparam logic [1:0] ADDR_LOADBUF  = 2'd3;

  // Limit after reset; truncated to the counter width at use
  localparam logic [31:0] RST_LIMIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/prog_counter_timer_if.sv
// Config port and status outputs of the counter/timer.
interface prog_counter_timer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             ena;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [7:0]       cfg_wdata;
  logic [WIDTH-1:0] count_o;
  logic             dir_o;
  logic             wrap_o;
  logic             done_o;
  logic             run_o;

  modport master (
    output ena, cfg_we, cfg_addr, cfg_wdata,
    input  count_o, dir_o, wrap_o, done_o, run_o
  );

  modport slave (
    input  ena, cfg_we, cfg_addr, cfg_wdata,
    output count_o, dir_o, wrap_o, done_o, run_o
  );
endinterface

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by (prescale+1) into a single-cycle tick.
module tick_prescaler #(
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt;

  assign tick = en && (pre_cnt == prescale);

  // Prescale counter: restarts on terminal, on clear, holds when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (clr || tick) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/prog_counter_timer.sv
// Programmable counter/timer with byte-serial config and wrap/done status.
module prog_counter_timer
  import prog_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PRE_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prog_counter_timer_if.slave  bus
);

  if ((WIDTH % 8 != 0) || (WIDTH < 8) || (WIDTH > 32)) begin : g_bad_width
    $error("prog_counter_timer: WIDTH must be a multiple of 8 in 8..32");
  end
  if (PRE_W != 8) begin : g_bad_pre_w
    $error("prog_counter_timer: PRE_W must be 8");
  end

  // State encoding is {done, run} so both status outputs come straight from flops
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]       state_q,    state_d;
  mode_e            mode_q,     mode_d;
  logic             dir_q,      dir_d;
  logic             wrap_q,     wrap_d;
  logic [WIDTH-1:0] count_q,    count_d;
  logic [WIDTH-1:0] limit_q,    limit_d;
  logic [WIDTH-1:0] loadbuf_q,  loadbuf_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;

  logic tick;
  logic pre_clr_c;

  assign pre_clr_c = bus.cfg_we &&
                     ((bus.cfg_addr == ADDR_PRESCALE) ||
                      ((bus.cfg_addr == ADDR_CTRL) && bus.cfg_wdata[CTRL_CLR]));

  tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.ena && (state_q == S_RUN)),
    .clr      (pre_clr_c),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_UP;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
      count_q    <= '0;
      limit_q    <= WIDTH'(RST_LIMIT);
      loadbuf_q  <= '0;
      prescale_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      loadbuf_q  <= loadbuf_d;
      prescale_q <= prescale_d;
    end
  end

  // Next state: a config write wins over a coincident tick
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    dir_d      = dir_q;
    wrap_d     = 1'b0;
    count_d    = count_q;
    limit_d    = limit_q;
    loadbuf_d  = loadbuf_q;
    prescale_d = prescale_q;

    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        ADDR_CTRL: begin
          mode_d = mode_e'(bus.cfg_wdata[CTRL_MODE_HI:CTRL_MODE_LO]);
          dir_d  = (mode_d == MODE_DOWN);
          if (bus.cfg_wdata[CTRL_RUN]) begin
            state_d = S_RUN;
          end else if (bus.cfg_wdata[CTRL_CLR] || (state_q == S_RUN)) begin
            state_d = S_IDLE;
          end
          if (bus.cfg_wdata[CTRL_CLR]) begin
            count_d = '0;
            dir_d   = 1'b0;
          end else if (bus.cfg_wdata[CTRL_LOAD]) begin
            count_d = loadbuf_q;
          end
        end
        ADDR_PRESCALE: prescale_d = PRE_W'(bus.cfg_wdata);
        ADDR_LIMIT:    limit_d    = WIDTH'({limit_q, bus.cfg_wdata});
        ADDR_LOADBUF:  loadbuf_d  = WIDTH'({loadbuf_q, bus.cfg_wdata});
        default: ;
      endcase
    end else if (tick) begin
      case (mode_q)
        MODE_UP: begin
          if (count_q >= limit_q) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (count_q == '0) begin
            count_d = limit_q;
            wrap_d  = 1'b1;
          end else if (count_q > limit_q) begin
            count_d = limit_q;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        MODE_PING: begin
          if (limit_q == '0) begin
            count_d = '0;
            dir_d   = 1'b0;
            wrap_d  = 1'b1;
          end else if (!dir_q) begin
            if (count_q >= limit_q) begin
              count_d = limit_q - WIDTH'(1);
              dir_d   = 1'b1;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end else begin
            if (count_q == '0) begin
              count_d = WIDTH'(1);
              dir_d   = 1'b0;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        MODE_ONESHOT: begin
          if (count_q >= limit_q) begin
            count_d = limit_q;
            state_d = S_DONE;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.count_o = count_q;
  assign bus.dir_o   = dir_q;
  assign bus.wrap_o  = wrap_q;
  assign bus.run_o   = state_q[0];
  assign bus.done_o  = state_q[1];

endmodule
